// File: rtl/uart_tx_core.sv
// uart_tx_core: parametrised UART transmitter.
// Accepts one word per valid/ready handshake and serialises it as
// start bit, DATA_W data bits (MSB- or LSB-first), optional parity,
// then STOP_BITS stop bits. Every line level lasts CLK_DIV cycles.
// The serial output is registered so it is glitch-free at the pin.
module uart_tx_core #(
   parameter int DATA_W    = 8,
   parameter int CLK_DIV   = 9,
   parameter int PARITY    = 1,
   parameter int MSB_FIRST = 1,
   parameter int STOP_BITS = 1
) (
   input  logic              clk_sys,
   input  logic              rst_n,
   input  logic [DATA_W-1:0] tx_data,
   input  logic              tx_vld,
   output logic              tx_rdy,
   output logic              tx_busy,
   output logic              tx_done,
   output logic              uart_tx
);

   // Counter widths: the bit-period counter spans 0..CLK_DIV-1, the index
   // counter covers up to 9 data bits or 2 stop bits.
   localparam int CNT_W = $clog2(CLK_DIV);
   localparam int IDX_W = 4;

   localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(CLK_DIV - 1);
   localparam logic [IDX_W-1:0] DATA_LAST = IDX_W'(DATA_W - 1);
   localparam logic [IDX_W-1:0] STOP_LAST = IDX_W'(STOP_BITS - 1);
   localparam bit               HAS_PAR   = (PARITY != 0);

   // Reject parameter sets the frame logic was not built for.
   generate
      if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
         $error("uart_tx_core: DATA_W must be 5..9");
      end
      if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
         $error("uart_tx_core: CLK_DIV must be 2..65535");
      end
      if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
         $error("uart_tx_core: PARITY must be 0, 1 or 2");
      end
      if (MSB_FIRST < 0 || MSB_FIRST > 1) begin : g_bad_msb_first
         $error("uart_tx_core: MSB_FIRST must be 0 or 1");
      end
      if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
         $error("uart_tx_core: STOP_BITS must be 1 or 2");
      end
   endgenerate

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_START  = 3'd1,
      S_DATA   = 3'd2,
      S_PARITY = 3'd3,
      S_STOP   = 3'd4
   } state_t;

   // Data bit to put on the line for a given transmit-order index.
   function automatic logic f_data_bit(input logic [DATA_W-1:0] word,
                                       input logic [IDX_W-1:0]  idx);
      logic [IDX_W-1:0]  pos;
      logic [DATA_W-1:0] shifted;
      if (MSB_FIRST != 0) begin
         pos = DATA_LAST - idx;
      end else begin
         pos = idx;
      end
      shifted = word >> pos;
      return shifted[0];
   endfunction

   // Parity bit: even mode is the plain XOR of the word, odd mode inverts it.
   function automatic logic f_parity(input logic [DATA_W-1:0] word);
      if (PARITY == 2) begin
         return ~(^word);
      end
      return ^word;
   endfunction

   state_t            r_state;
   logic [CNT_W-1:0]  r_cnt;
   logic [IDX_W-1:0]  r_idx;
   logic [DATA_W-1:0] r_word;
   logic              r_par;
   logic              r_tx;
   logic              r_rdy;

   state_t            w_state_nxt;
   logic [CNT_W-1:0]  w_cnt_nxt;
   logic [IDX_W-1:0]  w_idx_nxt;
   logic              w_tx_nxt;
   logic              w_rdy_nxt;
   logic              w_done;
   logic              w_accept;
   logic              w_bit_end;

   // A handshake only counts outside reset; reset wins over a valid word.
   assign w_accept  = rst_n & tx_vld & r_rdy;
   assign w_bit_end = (r_cnt == CNT_LAST);

   // Next-state, next line level and handshake decode for the frame FSM.
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = w_bit_end ? '0 : r_cnt + 1'b1;
      w_idx_nxt   = r_idx;
      w_tx_nxt    = r_tx;
      w_rdy_nxt   = r_rdy;
      w_done      = 1'b0;

      case (r_state)
         S_IDLE: begin
            // Counters are parked at zero so the start bit lasts exactly
            // CLK_DIV cycles from the acceptance edge.
            w_cnt_nxt = '0;
            w_idx_nxt = '0;
            w_tx_nxt  = 1'b1;
            w_rdy_nxt = 1'b1;
            if (w_accept) begin
               w_state_nxt = S_START;
               w_tx_nxt    = 1'b0;
               w_rdy_nxt   = 1'b0;
            end
         end

         S_START: begin
            if (w_bit_end) begin
               w_state_nxt = S_DATA;
               w_idx_nxt   = '0;
               w_tx_nxt    = f_data_bit(r_word, '0);
            end
         end

         S_DATA: begin
            if (w_bit_end) begin
               if (r_idx == DATA_LAST) begin
                  w_idx_nxt = '0;
                  if (HAS_PAR) begin
                     w_state_nxt = S_PARITY;
                     w_tx_nxt    = r_par;
                  end else begin
                     w_state_nxt = S_STOP;
                     w_tx_nxt    = 1'b1;
                  end
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
                  w_tx_nxt  = f_data_bit(r_word, r_idx + 1'b1);
               end
            end
         end

         S_PARITY: begin
            if (w_bit_end) begin
               w_state_nxt = S_STOP;
               w_idx_nxt   = '0;
               w_tx_nxt    = 1'b1;
            end
         end

         S_STOP: begin
            if (w_bit_end) begin
               if (r_idx == STOP_LAST) begin
                  // Final cycle of the last stop bit: flag completion and
                  // offer the next handshake from the following edge.
                  w_state_nxt = S_IDLE;
                  w_idx_nxt   = '0;
                  w_tx_nxt    = 1'b1;
                  w_rdy_nxt   = 1'b1;
                  w_done      = rst_n;
               end else begin
                  w_idx_nxt = r_idx + 1'b1;
               end
            end
         end

         default: begin
            w_state_nxt = S_IDLE;
            w_cnt_nxt   = '0;
            w_idx_nxt   = '0;
            w_tx_nxt    = 1'b1;
            w_rdy_nxt   = 1'b0;
         end
      endcase
   end

   // Control state register; reset aborts any frame and idles the line.
   always_ff @(posedge clk_sys) begin
      if (!rst_n) begin
         r_state <= S_IDLE;
         r_cnt   <= '0;
         r_idx   <= '0;
         r_tx    <= 1'b1;
         r_rdy   <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
         r_idx   <= w_idx_nxt;
         r_tx    <= w_tx_nxt;
         r_rdy   <= w_rdy_nxt;
      end
   end

   // Word and its parity are captured once, on acceptance only.
   always_ff @(posedge clk_sys) begin
      if (w_accept) begin
         r_word <= tx_data;
         r_par  <= f_parity(tx_data);
      end
   end

   assign tx_rdy  = r_rdy;
   assign tx_busy = (r_state != S_IDLE);
   assign tx_done = w_done;
   assign uart_tx = r_tx;

endmodule

// File: tb/tb_uart_tx_core.sv
// tb_uart_tx_core: three differently configured transmitters driven by
// directed and random stimulus, compared every cycle against a frame model
// that derives each line level from the position inside the frame.
module tb_uart_tx_core;

   logic       clk = 1'b0;
   logic       rst_n;
   logic [2:0] vld;
   logic [8:0] dat [3];
   wire  [2:0] o_rdy;
   wire  [2:0] o_busy;
   wire  [2:0] o_done;
   wire  [2:0] o_tx;

   int n_err = 0;
   int n_chk = 0;
   bit chk_en = 1'b0;
   int cyc = 0;

   // Reference model state per instance.
   int         m_pos   [3];
   logic [8:0] m_word  [3];
   int         acc_cyc [3];
   int         n_done  [3];
   bit   [2:0] m_rdy;
   bit   [2:0] m_acc;

   always #5 clk = ~clk;

   // u0: defaults. u1: 7 bits, LSB-first, odd parity, 2 stops, /4. u2: no parity.
   uart_tx_core #(.DATA_W(8), .CLK_DIV(9), .PARITY(1), .MSB_FIRST(1), .STOP_BITS(1)) u0 (
      .clk_sys(clk), .rst_n(rst_n), .tx_data(dat[0][7:0]), .tx_vld(vld[0]),
      .tx_rdy(o_rdy[0]), .tx_busy(o_busy[0]), .tx_done(o_done[0]), .uart_tx(o_tx[0]));
   uart_tx_core #(.DATA_W(7), .CLK_DIV(4), .PARITY(2), .MSB_FIRST(0), .STOP_BITS(2)) u1 (
      .clk_sys(clk), .rst_n(rst_n), .tx_data(dat[1][6:0]), .tx_vld(vld[1]),
      .tx_rdy(o_rdy[1]), .tx_busy(o_busy[1]), .tx_done(o_done[1]), .uart_tx(o_tx[1]));
   uart_tx_core #(.DATA_W(8), .CLK_DIV(9), .PARITY(0), .MSB_FIRST(1), .STOP_BITS(1)) u2 (
      .clk_sys(clk), .rst_n(rst_n), .tx_data(dat[2][7:0]), .tx_vld(vld[2]),
      .tx_rdy(o_rdy[2]), .tx_busy(o_busy[2]), .tx_done(o_done[2]), .uart_tx(o_tx[2]));

   function automatic int dw_of(input int i);
      return (i == 1) ? 7 : 8;
   endfunction
   function automatic int cd_of(input int i);
      return (i == 1) ? 4 : 9;
   endfunction
   function automatic int par_of(input int i);
      return (i == 0) ? 1 : ((i == 1) ? 2 : 0);
   endfunction
   function automatic int msb_of(input int i);
      return (i == 1) ? 0 : 1;
   endfunction
   function automatic int sb_of(input int i);
      return (i == 1) ? 2 : 1;
   endfunction
   function automatic int len_of(input int i);
      return (1 + dw_of(i) + ((par_of(i) != 0) ? 1 : 0) + sb_of(i)) * cd_of(i);
   endfunction

   // Line level at cycle 'pos' of a frame carrying word 'w'.
   function automatic int lvl(input int i, input int pos, input logic [8:0] w);
      int dw;
      int slot;
      int k;
      int ones;
      dw   = dw_of(i);
      slot = pos / cd_of(i);
      if (slot == 0) return 0;
      if (slot <= dw) begin
         k = slot - 1;
         return (msb_of(i) != 0) ? int'(w[dw - 1 - k]) : int'(w[k]);
      end
      if (par_of(i) != 0 && slot == dw + 1) begin
         ones = 0;
         for (int j = 0; j < dw; j++) ones += int'(w[j]);
         return (par_of(i) == 1) ? (ones % 2) : (1 - ones % 2);
      end
      return 1;
   endfunction

   task automatic check(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs != exp) begin
         n_err++;
         $display("FAIL %s: got %0d expected %0d at cycle %0d", tag, obs, exp, cyc);
      end
   endtask

   // Model: advance one cycle per rising edge.
   always @(posedge clk) begin
      cyc <= cyc + 1;
      for (int i = 0; i < 3; i++) begin
         m_acc[i] <= 1'b0;
         if (!rst_n) begin
            m_pos[i] <= -1;
            m_rdy[i] <= 1'b0;
         end else if (m_pos[i] >= 0) begin
            if (m_pos[i] == len_of(i) - 1) begin
               m_pos[i] <= -1;
               m_rdy[i] <= 1'b1;
            end else begin
               m_pos[i] <= m_pos[i] + 1;
            end
         end else if (vld[i] && m_rdy[i]) begin
            m_word[i]  <= dat[i];
            m_pos[i]   <= 0;
            m_rdy[i]   <= 1'b0;
            m_acc[i]   <= 1'b1;
            acc_cyc[i] <= cyc + 1;
         end else begin
            m_rdy[i] <= 1'b1;
         end
      end
   end

   // Compare every output of every instance on the falling edge.
   always @(negedge clk) begin
      if (chk_en) begin
         for (int i = 0; i < 3; i++) begin
            check($sformatf("u%0d uart_tx", i), int'(o_tx[i]),
                  (m_pos[i] >= 0) ? lvl(i, m_pos[i], m_word[i]) : 1);
            check($sformatf("u%0d tx_busy", i), int'(o_busy[i]), (m_pos[i] >= 0) ? 1 : 0);
            check($sformatf("u%0d tx_done", i), int'(o_done[i]),
                  (rst_n && m_pos[i] == len_of(i) - 1) ? 1 : 0);
            check($sformatf("u%0d tx_rdy", i), int'(o_rdy[i]), int'(m_rdy[i]));
            if (o_done[i]) begin
               n_done[i]++;
               check($sformatf("u%0d frame_len", i), cyc - acc_cyc[i] + 1, len_of(i));
            end
         end
      end
   end

   task automatic wait_acc(input int i);
      int t;
      t = 0;
      while (1) begin
         @(posedge clk); #1;
         if (m_acc[i]) break;
         t++;
         if (t > 400) begin
            check($sformatf("u%0d accept_timeout", i), 0, 1);
            break;
         end
      end
   endtask

   task automatic send(input int i, input logic [8:0] w);
      dat[i] = w;
      vld[i] = 1'b1;
      wait_acc(i);
      vld[i] = 1'b0;
   endtask

   task automatic wait_idle();
      int t;
      t = 0;
      while (m_pos[0] >= 0 || m_pos[1] >= 0 || m_pos[2] >= 0) begin
         @(posedge clk); #1;
         t++;
         if (t > 600) begin
            check("idle_timeout", 0, 1);
            break;
         end
      end
      @(posedge clk); #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int d;
      int a1;
      int t;
      rst_n = 1'b0;
      vld   = '0;
      for (int i = 0; i < 3; i++) begin
         dat[i]    = '0;
         n_done[i] = 0;
      end

      // Reset held for five edges.
      @(posedge clk); #1;
      chk_en = 1'b1;
      repeat (4) begin
         @(posedge clk); #1;
      end
      check("reset uart_tx", int'(o_tx[0]), 1);
      check("reset tx_rdy", int'(o_rdy[0]), 0);
      check("reset tx_busy", int'(o_busy[0]), 0);
      check("reset tx_done", int'(o_done[0]), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rdy after release", int'(o_rdy[0]), 1);

      // One frame on each configuration.
      fork
         send(0, 9'h055);
         send(1, 9'h003);
         send(2, 9'h0FF);
      join
      wait_idle();

      // Back-to-back with tx_vld held on the default instance.
      d = n_done[0];
      dat[0] = 9'h0AA;
      vld[0] = 1'b1;
      wait_acc(0);
      a1 = acc_cyc[0];
      dat[0] = 9'h055;
      wait_acc(0);
      vld[0] = 1'b0;
      check("b2b accept spacing", acc_cyc[0] - a1, 100);
      wait_idle();
      check("b2b done pulses", n_done[0] - d, 2);

      // Reset during data bit 3 of 0x55, then a clean 0xAA frame.
      send(0, 9'h055);
      t = 0;
      while (m_pos[0] != 38 && t < 200) begin
         @(posedge clk); #1;
         t++;
      end
      check("reach data bit 3", m_pos[0], 38);
      d = n_done[0];
      rst_n = 1'b0;
      @(posedge clk); #1;
      check("abort uart_tx", int'(o_tx[0]), 1);
      check("abort tx_busy", int'(o_busy[0]), 0);
      rst_n = 1'b1;
      @(posedge clk); #1;
      check("rdy after abort", int'(o_rdy[0]), 1);
      check("no done on abort", n_done[0] - d, 0);
      send(0, 9'h0AA);
      wait_idle();
      check("done after abort frame", n_done[0] - d, 1);

      // Random traffic: valid toggling while busy, changing data, rare resets.
      for (int c = 0; c < 5000; c++) begin
         for (int i = 0; i < 3; i++) begin
            vld[i] = ($urandom_range(0, 3) != 0);
            dat[i] = 9'($urandom_range(0, 511));
         end
         rst_n = ($urandom_range(0, 699) != 0);
         @(posedge clk); #1;
      end
      vld   = '0;
      rst_n = 1'b1;
      wait_idle();
      repeat (3) begin
         @(posedge clk); #1;
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/uart_tx_core.md
Name: uart_tx_core

Overview:
Synthesizable, parametrised UART transmitter for the FPGA fabric, running on the system clock. It serialises words handed over on a valid/ready handshake into frames on the serial line. Each frame is: start bit, data bits (MSB-first or LSB-first), optional even/odd parity, then 1 or 2 stop bits. It generalises the fixed 8-bit, MSB-first, XOR-parity frame format used on the board link to configurable width, bit order, parity mode, stop bits and bit period.

Parameters:
DATA_W, 8, data bits per frame; legal 5..9.
CLK_DIV, 9, clk_sys cycles per bit period; legal 2..65535.
PARITY, 1, 0 = none, 1 = even (parity bit = XOR of data bits), 2 = odd (inverted XOR).
MSB_FIRST, 1, 1 = bit DATA_W-1 sent first, 0 = bit 0 sent first.
STOP_BITS, 1, number of stop bit periods; legal 1 or 2.

Ports:
clk_sys  input  1  system clock; all logic on rising edge.
rst_n  input  1  synchronous active-low reset.
tx_data  input  DATA_W  word to transmit; sampled only on acceptance.
tx_vld  input  1  tx_data valid.
tx_rdy  output  1  core idle and able to accept a word.
tx_busy  output  1  frame in progress (start through last stop bit).
tx_done  output  1  one-cycle pulse on the final cycle of the last stop bit.
uart_tx  output  1  serial line; idle high; registered.

Behaviour:
- Reset (rst_n=0 at a rising edge): uart_tx=1, tx_rdy=0, tx_busy=0, tx_done=0, FSM=IDLE, counters=0. tx_rdy rises on the first edge with rst_n=1.
- Reset mid-frame: frame aborted at that edge; uart_tx=1 immediately (registered); shift data discarded; no tx_done.
- Acceptance: when tx_vld=1 and tx_rdy=1 at an edge, tx_data is latched. The same edge clears tx_rdy. The parity bit is computed from the latched word.
- FSM states: IDLE -> START -> DATA -> PARITY (skipped when PARITY=0) -> STOP -> IDLE.
- Each state holds uart_tx for exactly CLK_DIV cycles.
- DATA holds for DATA_W bit periods. STOP holds for STOP_BITS bit periods.
- Latency: acceptance at edge N puts uart_tx=0 (start bit) from edge N+1.
- Frame length = (1 + DATA_W + (PARITY!=0) + STOP_BITS) * CLK_DIV cycles.
- Bit counter: 0..CLK_DIV-1 per bit; wraps to 0 at each bit boundary; no drift across a frame.
- Data-bit index: counts 0..DATA_W-1. Bit order is selected by MSB_FIRST.
- tx_busy=1 from edge N+1 through the last cycle of STOP; 0 otherwise.
- tx_done=1 for exactly the last clk_sys cycle of the final stop bit. tx_rdy returns to 1 on the following edge.
- Back-to-back: if tx_vld is held, the next acceptance occurs the cycle tx_rdy=1. The next start bit follows one cycle later, so the inter-frame idle gap is 1 clk_sys cycle.
- tx_vld while busy: ignored. tx_data is not re-sampled.
- tx_vld and rst_n=0 at the same edge: reset wins; no acceptance.
- Illegal parameter values: rejected at elaboration (generate-time check). No runtime behaviour is defined for them.

Test Plan:
- Reset check: hold rst_n=0 for 5 cycles -> uart_tx=1, tx_rdy=0, tx_busy=0, tx_done=0. Release -> tx_rdy=1 one cycle later.
- Defaults (DATA_W=8, CLK_DIV=9, PARITY=1, MSB_FIRST=1, STOP_BITS=1), send 0x55 -> line sequence 0,0,1,0,1,0,1,0,1,0(parity),1(stop), each level 9 cycles. Total 99 cycles. tx_done pulse in cycle 99.
- Defaults, tx_vld held with 0xAA then 0x55 -> 0xAA frame 0,1,0,1,0,1,0,1,0,0,1. Then a 1-cycle idle gap. Then the 0x55 frame. Exactly two tx_done pulses.
- PARITY=2, MSB_FIRST=0, STOP_BITS=2, DATA_W=7, CLK_DIV=4, send 0x03 -> 0,1,1,0,0,0,0,0,1(odd parity),1,1. Each level 4 cycles. Total 44 cycles.
- PARITY=0, send 0xFF -> no parity slot: 0, then eight 1s, then stop. Frame 90 cycles.
- Reset mid-frame: assert rst_n=0 during data bit 3 of 0x55 -> uart_tx=1 the next cycle, no tx_done, tx_rdy=1 one cycle after release. A new 0xAA frame is then correct.
